// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory-side responder: grants requests, updates a word array, returns in-order responses after LATENCY cycles.
// Defining CV32E40P_OBI_RESP_STALL_EN enables LFSR-driven random grant stalls.
module cv32e40p_obi_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]        r_mem [MEM_WORDS];
    logic [LATENCY-1:0] r_pipe_vld;
    logic [31:0]        r_pipe_data [LATENCY];
    logic [CNT_W-1:0]   r_outstanding;

    logic             w_stall;
    logic             w_retire;
    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_word;
    logic             w_unused_addr;

    assign w_idx         = addr_i[IDX_W+1:2];
    assign w_unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};
    assign w_rd_word     = r_mem[w_idx];

    assign w_retire = r_pipe_vld[LATENCY-1];
    assign gnt_o    = req_i && !rst_i && !w_stall &&
                      ((r_outstanding < CNT_W'(MAX_OUTSTANDING)) || w_retire);
    assign w_accept = req_i && gnt_o;

    assign rvalid_o = r_pipe_vld[LATENCY-1];
    assign rdata_o  = r_pipe_data[LATENCY-1];

`ifdef CV32E40P_OBI_RESP_STALL_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr <= STALL_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    logic w_unused_seed;
    assign w_unused_seed = ^STALL_SEED;
    assign w_stall       = 1'b0;
`endif

    // Array is intentionally not reset; granted writes survive a mid-run reset
    always_ff @(posedge clk_i) begin
        if (w_accept && we_i) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response pipe; write responses carry zero data so rdata_o needs no gating
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pipe_vld <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_pipe_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
            r_pipe_vld[0]  <= w_accept;
            r_pipe_data[0] <= (w_accept && !we_i) ? w_rd_word : 32'h0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_retire})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule
